// File: rtl/uart_instr_assembler.sv
// uart_instr_assembler: packs UART bytes (first byte = MSB) into INSTR_BYTES-wide
// words, queues them in a show-ahead FIFO with a valid/ready handshake, drops
// partial words that stall past TIMEOUT_CLKS, and exports the last byte.
// Optional byte echo to UART_TX is built only when UART_ECHO_EN is defined.
module uart_instr_assembler #(
  parameter int INSTR_BYTES  = 4,
  parameter int FIFO_DEPTH   = 8,
  parameter int TIMEOUT_CLKS = 1000
) (
  input  logic                            i_Clk,
  input  logic                            i_Rst_L,
  input  logic                            i_RX_DV,
  input  logic [7:0]                      i_RX_Byte,
  output logic [8*INSTR_BYTES-1:0]        o_Instr,
  output logic                            o_Instr_Valid,
  input  logic                            i_Instr_Ready,
  output logic [$clog2(FIFO_DEPTH):0]     o_Fill,
  output logic                            o_Overflow,
  output logic                            o_Frame_Err,
  input  logic                            i_Clear_Err,
  output logic [7:0]                      o_Last_Byte,
  input  logic                            i_TX_Done,
  output logic                            o_TX_DV,
  output logic [7:0]                      o_TX_Byte,
  output logic                            o_Echo_Drop
);

  localparam int WORD_W = 8 * INSTR_BYTES;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FILL_W = PTR_W + 1;
  localparam int CNT_W  = $clog2(INSTR_BYTES) + 1;
  localparam int TMR_W  = (TIMEOUT_CLKS > 0) ? $clog2(TIMEOUT_CLKS + 1) : 1;
  localparam bit TMO_EN = (TIMEOUT_CLKS > 0);

  typedef enum logic {IDLE, ASSEMBLE} state_t;

  state_t              state, state_n;
  logic [CNT_W-1:0]    count, count_n, base_count;
  logic [WORD_W-1:0]   shift, shift_n, base_shift, next_word;
  logic [TMR_W-1:0]    timer, timer_n;
  logic                timeout;
  logic                push_req, push_ok, pop, full;
  logic                ovf_set, frame_set;

  logic [WORD_W-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [FILL_W-1:0]   fill;

  assign timeout = TMO_EN && (state == ASSEMBLE) && (timer >= TMR_W'(TIMEOUT_CLKS));
  assign full    = (fill == FILL_W'(FIFO_DEPTH));
  assign pop     = o_Instr_Valid && i_Instr_Ready;
  assign push_ok = push_req && (!full || pop);
  assign ovf_set = push_req && full && !pop;

  // Assembler state register: byte count, shift register and inter-byte timer.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state <= IDLE;
      count <= '0;
      shift <= '0;
      timer <= '0;
    end else begin
      state <= state_n;
      count <= count_n;
      shift <= shift_n;
      timer <= timer_n;
    end
  end

  // Next-state: a timeout clears the partial word first, so a byte in the same
  // cycle becomes byte 0 of a fresh word.
  always_comb begin
    state_n    = state;
    count_n    = count;
    shift_n    = shift;
    timer_n    = timer;
    push_req   = 1'b0;
    frame_set  = 1'b0;
    base_count = count;
    base_shift = shift;
    if (timeout) begin
      base_count = '0;
      base_shift = '0;
      frame_set  = 1'b1;
      state_n    = IDLE;
      count_n    = '0;
      shift_n    = '0;
      timer_n    = '0;
    end else if (state == ASSEMBLE) begin
      timer_n = timer + TMR_W'(1);
    end
    next_word = (base_shift << 8) | WORD_W'(i_RX_Byte);
    if (i_RX_DV) begin
      timer_n = '0;
      if (base_count == CNT_W'(INSTR_BYTES - 1)) begin
        push_req = 1'b1;
        count_n  = '0;
        shift_n  = '0;
        state_n  = IDLE;
      end else begin
        count_n = base_count + CNT_W'(1);
        shift_n = next_word;
        state_n = ASSEMBLE;
      end
    end
  end

  // Word FIFO: push of the completed word, pop on handshake, full push+pop keeps fill.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= next_word;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   fill <= fill + FILL_W'(1);
        2'b01:   fill <= fill - FILL_W'(1);
        default: fill <= fill;
      endcase
    end
  end

  assign o_Instr       = mem[rd_ptr];
  assign o_Instr_Valid = (fill != '0);
  assign o_Fill        = fill;

  // Sticky error flags and display byte; a set in the clearing cycle wins.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      o_Overflow  <= 1'b0;
      o_Frame_Err <= 1'b0;
      o_Last_Byte <= '0;
    end else begin
      o_Overflow  <= ovf_set   | (o_Overflow  & ~i_Clear_Err);
      o_Frame_Err <= frame_set | (o_Frame_Err & ~i_Clear_Err);
      if (i_RX_DV) o_Last_Byte <= i_RX_Byte;
    end
  end

`ifdef UART_ECHO_EN
  logic       echo_vld, tx_busy, launch;
  logic [7:0] echo_byte;

  assign launch    = echo_vld && !tx_busy;
  assign o_TX_DV   = launch;
  assign o_TX_Byte = launch ? echo_byte : 8'h00;

  // One-entry echo buffer; a slot freed by a launch can take a new byte that cycle.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      echo_vld    <= 1'b0;
      echo_byte   <= '0;
      tx_busy     <= 1'b0;
      o_Echo_Drop <= 1'b0;
    end else begin
      if (i_RX_DV && (!echo_vld || launch)) begin
        echo_vld  <= 1'b1;
        echo_byte <= i_RX_Byte;
      end else if (launch) begin
        echo_vld <= 1'b0;
      end
      if (launch)         tx_busy <= 1'b1;
      else if (i_TX_Done) tx_busy <= 1'b0;
      o_Echo_Drop <= (i_RX_DV && echo_vld && !launch) | (o_Echo_Drop & ~i_Clear_Err);
    end
  end
`else
  logic unused_tx_done;
  assign unused_tx_done = i_TX_Done;
  assign o_TX_DV        = 1'b0;
  assign o_TX_Byte      = 8'h00;
  assign o_Echo_Drop    = 1'b0;
`endif

endmodule

// File: tb/tb_uart_instr_assembler.sv
// Bench for uart_instr_assembler (INSTR_BYTES=4, FIFO_DEPTH=8, TIMEOUT_CLKS=20):
// directed scenarios plus randomized traffic against a queue-based reference model.
module tb_uart_instr_assembler;
  localparam int IB  = 4;
  localparam int DEP = 8;
  localparam int TMO = 20;

  logic        i_Clk = 1'b0;
  logic        i_Rst_L = 1'b0;
  logic        i_RX_DV = 1'b0;
  logic [7:0]  i_RX_Byte = '0;
  logic [31:0] o_Instr;
  logic        o_Instr_Valid;
  logic        i_Instr_Ready = 1'b0;
  logic [3:0]  o_Fill;
  logic        o_Overflow, o_Frame_Err;
  logic        i_Clear_Err = 1'b0;
  logic [7:0]  o_Last_Byte;
  logic        i_TX_Done = 1'b0;
  logic        o_TX_DV;
  logic [7:0]  o_TX_Byte;
  logic        o_Echo_Drop;

  uart_instr_assembler #(.INSTR_BYTES(IB), .FIFO_DEPTH(DEP), .TIMEOUT_CLKS(TMO)) dut (
    .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_RX_DV(i_RX_DV), .i_RX_Byte(i_RX_Byte),
    .o_Instr(o_Instr), .o_Instr_Valid(o_Instr_Valid), .i_Instr_Ready(i_Instr_Ready),
    .o_Fill(o_Fill), .o_Overflow(o_Overflow), .o_Frame_Err(o_Frame_Err),
    .i_Clear_Err(i_Clear_Err), .o_Last_Byte(o_Last_Byte), .i_TX_Done(i_TX_Done),
    .o_TX_DV(o_TX_DV), .o_TX_Byte(o_TX_Byte), .o_Echo_Drop(o_Echo_Drop)
  );

  always #5 i_Clk = ~i_Clk;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [31:0] mq[$];
  logic [7:0]  part[$];
  int          gap = 0;
  bit          m_ovf = 0, m_ferr = 0;
  logic [7:0]  m_last = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    part.delete();
    gap = 0; m_ovf = 0; m_ferr = 0; m_last = '0;
  endtask

  task automatic model_step(input bit dv, input logic [7:0] b, input bit rdy, input bit clr);
    bit pop, full, so, sf;
    logic [31:0] w;
    pop = (mq.size() > 0) && rdy;
    full = (mq.size() == DEP);
    so = 0; sf = 0;
    if (pop) void'(mq.pop_front());
    if (part.size() > 0 && gap >= TMO) begin
      part.delete(); sf = 1; gap = 0;
    end
    if (dv) begin
      part.push_back(b);
      m_last = b;
      gap = 0;
      if (part.size() == IB) begin
        w = 0;
        foreach (part[i]) w = (w << 8) | 32'(part[i]);
        if (full && !pop) so = 1;
        else mq.push_back(w);
        part.delete();
      end
    end else if (part.size() > 0) begin
      gap++;
    end
    m_ovf  = so | (m_ovf & ~clr);
    m_ferr = sf | (m_ferr & ~clr);
  endtask

  task automatic check_all();
    chk("valid", 64'(o_Instr_Valid), 64'(mq.size() > 0));
    chk("fill", 64'(o_Fill), 64'(mq.size()));
    if (mq.size() > 0) chk("instr", 64'(o_Instr), 64'(mq[0]));
    chk("overflow", 64'(o_Overflow), 64'(m_ovf));
    chk("frame_err", 64'(o_Frame_Err), 64'(m_ferr));
    chk("last_byte", 64'(o_Last_Byte), 64'(m_last));
`ifndef UART_ECHO_EN
    chk("tx_dv_tied", 64'(o_TX_DV), 64'd0);
    chk("echo_drop_tied", 64'(o_Echo_Drop), 64'd0);
`endif
  endtask

  task automatic cyc(input bit dv, input logic [7:0] b, input bit rdy, input bit clr, input bit done);
    i_RX_DV = dv; i_RX_Byte = b; i_Instr_Ready = rdy; i_Clear_Err = clr; i_TX_Done = done;
    @(posedge i_Clk);
    model_step(dv, b, rdy, clr);
    #1;
    i_RX_DV = 0; i_Instr_Ready = 0; i_Clear_Err = 0; i_TX_Done = 0;
    check_all();
  endtask

  task automatic send_word(input logic [31:0] w, input bit rdy_last);
    logic [31:0] v;
    v = w;
    for (int k = 0; k < IB; k++)
      cyc(1'b1, v[31-8*k -: 8], (k == IB-1) ? rdy_last : 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int k = 0; k < 2*DEP; k++) cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
  endtask

  logic [31:0] sent[9];

  initial begin
    // Reset state
    repeat (3) @(posedge i_Clk);
    #1;
    chk("rst_instr", 64'(o_Instr), 0);
    chk("rst_valid", 64'(o_Instr_Valid), 0);
    chk("rst_fill", 64'(o_Fill), 0);
    chk("rst_txdv", 64'(o_TX_DV), 0);
    i_Rst_L = 1'b1;
    check_all();

    // Basic word assembly
    send_word(32'h12345678, 1'b0);
    chk("t1_instr", 64'(o_Instr), 64'h12345678);
    chk("t1_valid", 64'(o_Instr_Valid), 1);
    chk("t1_last", 64'(o_Last_Byte), 64'h78);
    chk("t1_fill", 64'(o_Fill), 1);
    drain();

    // Nine words into an eight-deep FIFO
    for (int n = 0; n < 9; n++) begin
      sent[n] = $urandom;
      send_word(sent[n], 1'b0);
    end
    chk("t2_fill", 64'(o_Fill), 8);
    chk("t2_ovf", 64'(o_Overflow), 1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    for (int n = 0; n < 8; n++) begin
      chk("t2_order", 64'(o_Instr), 64'(sent[n]));
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    chk("t2_empty", 64'(o_Fill), 0);

    // Full FIFO, push and pop in the same cycle
    for (int n = 0; n < 8; n++) begin
      sent[n] = $urandom;
      send_word(sent[n], 1'b0);
    end
    sent[8] = $urandom;
    send_word(sent[8], 1'b1);
    chk("t3_fill", 64'(o_Fill), 8);
    chk("t3_ovf", 64'(o_Overflow), 0);
    for (int n = 1; n < 9; n++) begin
      chk("t3_order", 64'(o_Instr), 64'(sent[n]));
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end

    // Timeout of a partial word
    send_word(32'h0, 1'b0);
    drain();
    cyc(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'hBB, 1'b0, 1'b0, 1'b0);
    repeat (TMO) cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("t4_noerr_yet", 64'(o_Frame_Err), 0);
    send_word(32'h01020304, 1'b0);
    chk("t4_ferr", 64'(o_Frame_Err), 1);
    chk("t4_fill", 64'(o_Fill), 1);
    chk("t4_instr", 64'(o_Instr), 64'h01020304);
    drain();
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // Randomized traffic including long gaps and error clears
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 40) == 0)
        repeat ($urandom_range(18, 24)) cyc(1'b0, 8'h00, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      cyc(1'($urandom_range(0, 99) < 60), 8'($urandom), 1'($urandom_range(0, 99) < 25),
          1'($urandom_range(0, 19) == 0), 1'b0);
    end
    drain();

    // Async reset mid-word
    cyc(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h66, 1'b0, 1'b0, 1'b0);
    #2 i_Rst_L = 1'b0;
    #1;
    model_reset();
    chk("t6_instr", 64'(o_Instr), 0);
    chk("t6_valid", 64'(o_Instr_Valid), 0);
    chk("t6_fill", 64'(o_Fill), 0);
    chk("t6_ovf", 64'(o_Overflow), 0);
    chk("t6_ferr", 64'(o_Frame_Err), 0);
    chk("t6_last", 64'(o_Last_Byte), 0);
    chk("t6_txdv", 64'(o_TX_DV), 0);
    chk("t6_drop", 64'(o_Echo_Drop), 0);
    @(posedge i_Clk);
    #1 i_Rst_L = 1'b1;

    // Fresh word after reset, with echo behaviour on the first bytes
    cyc(1'b1, 8'hA1, 1'b0, 1'b0, 1'b0);
`ifdef UART_ECHO_EN
    chk("e_launch1", 64'(o_TX_DV), 1);
    chk("e_byte1", 64'(o_TX_Byte), 64'hA1);
`endif
    cyc(1'b1, 8'hB2, 1'b0, 1'b0, 1'b0);
`ifdef UART_ECHO_EN
    chk("e_gap1", 64'(o_TX_DV), 0);
    chk("e_nodrop", 64'(o_Echo_Drop), 0);
`endif
    cyc(1'b1, 8'hC3, 1'b0, 1'b0, 1'b0);
`ifdef UART_ECHO_EN
    chk("e_busy", 64'(o_TX_DV), 0);
    chk("e_drop", 64'(o_Echo_Drop), 1);
`endif
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
`ifdef UART_ECHO_EN
    chk("e_wait", 64'(o_TX_DV), 0);
`endif
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
`ifdef UART_ECHO_EN
    chk("e_launch2", 64'(o_TX_DV), 1);
    chk("e_byte2", 64'(o_TX_Byte), 64'hB2);
`endif
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
`ifdef UART_ECHO_EN
    chk("e_single", 64'(o_TX_DV), 0);
`endif
    cyc(1'b1, 8'hD4, 1'b0, 1'b0, 1'b0);
    chk("t6_word", 64'(o_Instr), 64'hA1B2C3D4);
    chk("t6_valid2", 64'(o_Instr_Valid), 1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
